// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a common-anode 7-segment
//             bank. Holds one frame of NDIG 6-bit codes (0-15 hex, 16 '=',
//             17 '+', 18 '-', 6'h3F blank) and walks the digits one slot at a
//             time, with an all-off guard interval at the start of each slot.
//             New frames arrive over a valid/ready port into a pending buffer.
//             The pending buffer is promoted only at the frame wrap, so the
//             display never tears.
//  Ports    : clk, rst_n                 clock / async active-low reset
//             en                         1 = scan runs, 0 = freeze and blank
//             upd_valid/upd_ready        frame offer handshake
//             upd_codes[6*NDIG-1:0]      frame codes, digit 0 = rightmost
//             upd_dp[NDIG-1:0]           decimal-point enables (1 = lit)
//             dig_code[5:0]              current code to the segment decoder
//             an[NDIG-1:0]               anode enables, active-low
//             dp_n                       decimal point, active-low
//             frame_start                pulse on first display cycle of digit 0
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NDIG      = 8,
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [6*NDIG-1:0] upd_codes,
    input  logic [NDIG-1:0]   upd_dp,
    output logic [5:0]        dig_code,
    output logic [NDIG-1:0]   an,
    output logic              dp_n,
    output logic              frame_start
);

    localparam int C_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int C_IDX_W = $clog2(NDIG);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST   = C_CNT_W'(DIV - 1);
    localparam logic [C_CNT_W-1:0] C_BLANK_LAST = C_CNT_W'(BLANK_CYC - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(NDIG - 1);
    localparam logic [5:0]         C_CODE_BLANK = 6'h3F;

    localparam logic [0:0] C_ST_BLANK = 1'b0;
    localparam logic [0:0] C_ST_SHOW  = 1'b1;

    logic [C_CNT_W-1:0] r_cnt;
    logic [C_IDX_W-1:0] r_idx;
    logic [0:0]         r_state;
    logic [6*NDIG-1:0]  r_act_codes;
    logic [NDIG-1:0]    r_act_dp;
    logic [6*NDIG-1:0]  r_pend_codes;
    logic [NDIG-1:0]    r_pend_dp;
    logic               r_pend_full;

    logic               w_slot_end;
    logic               w_wrap;
    logic               w_accept;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic [C_IDX_W-1:0] w_idx_nxt;
    logic [0:0]         w_state_nxt;
    logic [NDIG-1:0]    w_an_nxt;
    logic               w_show_start;

    assign upd_ready  = ~r_pend_full;
    assign w_accept   = upd_valid & ~r_pend_full;
    assign w_slot_end = (r_cnt == C_CNT_LAST);
    // Frame wrap only counts while scanning; a frozen display never promotes.
    assign w_wrap     = en & w_slot_end & (r_idx == C_IDX_LAST);

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_state_nxt = r_state;
        if (en) begin
            w_cnt_nxt = w_slot_end ? '0 : r_cnt + C_CNT_W'(1);
            if (w_slot_end) begin
                w_idx_nxt = (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IDX_W'(1);
            end
            case (r_state)
                C_ST_BLANK: if (r_cnt == C_BLANK_LAST) w_state_nxt = C_ST_SHOW;
                C_ST_SHOW:  if (w_slot_end)            w_state_nxt = C_ST_BLANK;
                default:                               w_state_nxt = C_ST_BLANK;
            endcase
        end
    end

    always_comb begin
        w_an_nxt            = '1;
        w_an_nxt[w_idx_nxt] = 1'b0;
    end

    assign w_show_start = en & (r_state == C_ST_BLANK) & (w_state_nxt == C_ST_SHOW);

    // Counters, FSM and the registered outputs. Outputs are computed from the
    // next-state values so they line up with the state of the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_state     <= C_ST_BLANK;
            an          <= '1;
            dp_n        <= 1'b1;
            dig_code    <= C_CODE_BLANK;
            frame_start <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_state     <= w_state_nxt;
            frame_start <= w_show_start & (w_idx_nxt == '0);
            if (en && (w_state_nxt == C_ST_SHOW)) begin
                an       <= w_an_nxt;
                dp_n     <= ~r_act_dp[w_idx_nxt];
                dig_code <= r_act_codes[int'(w_idx_nxt)*6 +: 6];
            end else begin
                an       <= '1;
                dp_n     <= 1'b1;
                dig_code <= C_CODE_BLANK;
            end
        end
    end

    // Frame buffers. An accept on the wrap cycle cannot collide with a
    // promotion because accept requires the pending slot to be empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_codes  <= {NDIG{C_CODE_BLANK}};
            r_act_dp     <= '0;
            r_pend_codes <= {NDIG{C_CODE_BLANK}};
            r_pend_dp    <= '0;
            r_pend_full  <= 1'b0;
        end else begin
            if (w_wrap && r_pend_full) begin
                r_act_codes <= r_pend_codes;
                r_act_dp    <= r_pend_dp;
            end
            if (w_accept) begin
                r_pend_codes <= upd_codes;
                r_pend_dp    <= upd_dp;
                r_pend_full  <= 1'b1;
            end else if (w_wrap) begin
                r_pend_full  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Directed self-checking bench for seg_scan_ctrl with NDIG=4,
//             DIV=8, BLANK_CYC=2 (one frame = 32 cycles). Tracks the scan
//             position itself to step to chosen slot/count points.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int NDIG = 4;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              upd_valid;
    logic              upd_ready;
    logic [6*NDIG-1:0] upd_codes;
    logic [NDIG-1:0]   upd_dp;
    logic [5:0]        dig_code;
    logic [NDIG-1:0]   an;
    logic              dp_n;
    logic              frame_start;

    int checks   = 0;
    int errors   = 0;
    int p        = 0;   // position in frame: idx*8 + cnt
    int cyc      = 0;
    int fs_last  = 0;
    bit fs_valid = 1'b0;

    seg_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK_CYC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_codes   (upd_codes),
        .upd_dp      (upd_dp),
        .dig_code    (dig_code),
        .an          (an),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock, sampled 1 ns after the edge, plus the always-on invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n)  p = 0;
        else if (en) p = (p + 1) % 32;
        chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
        if (!rst_n || !en) begin
            fs_valid = 1'b0;
            chk("fs_quiet", 32'(frame_start), 32'd0);
        end else if (frame_start) begin
            if (fs_valid) chk("fs_period", 32'(cyc - fs_last), 32'd32);
            fs_last  = cyc;
            fs_valid = 1'b1;
        end
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (p != target && n < 200) begin
            tick();
            n++;
        end
        if (p != target) chk("run_to_timeout", 32'(p), 32'(target));
    endtask

    task automatic show(input string tag, input logic [3:0] e_an,
                        input logic [5:0] e_code, input logic e_dpn);
        chk({tag, "_an"},   32'(an),       32'(e_an));
        chk({tag, "_code"}, 32'(dig_code), 32'(e_code));
        chk({tag, "_dpn"},  32'(dp_n),     32'(e_dpn));
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        upd_valid = 1'b0;
        upd_codes = '0;
        upd_dp    = '0;

        // ---- Reset and idle scan ----
        repeat (3) tick();
        show("rst", 4'b1111, 6'h3F, 1'b1);
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        rst_n = 1'b1;
        chk("c0_an", 32'(an), 32'hF);
        tick();
        chk("c1_an", 32'(an), 32'hF);
        tick();
        show("c2", 4'b1110, 6'h3F, 1'b1);
        chk("c2_fs", 32'(frame_start), 32'd1);
        tick();
        chk("c3_fs", 32'(frame_start), 32'd0);
        run_to(7);
        chk("c7_an", 32'(an), 32'hE);
        run_to(8);
        chk("c8_an", 32'(an), 32'hF);
        run_to(10);
        show("c10", 4'b1101, 6'h3F, 1'b1);

        // ---- Push {18,17,16,5} dp=0001 while idle ----
        upd_codes = {6'd18, 6'd17, 6'd16, 6'd5};
        upd_dp    = 4'b0001;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("push_ready_low", 32'(upd_ready), 32'd0);
        chk("pend_hidden", 32'(dig_code), 32'h3F);
        run_to(31);
        chk("pre_wrap_ready", 32'(upd_ready), 32'd0);
        show("pre_wrap", 4'b0111, 6'h3F, 1'b1);
        tick();
        chk("post_wrap_ready", 32'(upd_ready), 32'd1);
        run_to(2);
        show("f1_d0", 4'b1110, 6'd5, 1'b0);
        run_to(10);
        show("f1_d1", 4'b1101, 6'd16, 1'b1);
        run_to(18);
        show("f1_d2", 4'b1011, 6'd17, 1'b1);
        run_to(26);
        show("f1_d3", 4'b0111, 6'd18, 1'b1);

        // ---- Accept on the exact wrap cycle ----
        run_to(31);
        upd_codes = {6'd1, 6'd2, 6'd3, 6'd4};
        upd_dp    = 4'b0000;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("wrap_acc_ready", 32'(upd_ready), 32'd0);
        run_to(2);
        show("wrap_old_d0", 4'b1110, 6'd5, 1'b0);
        run_to(26);
        chk("wrap_old_d3", 32'(dig_code), 32'd18);
        run_to(31);
        chk("wrap_pend_ready", 32'(upd_ready), 32'd0);
        tick();
        chk("wrap_prom_ready", 32'(upd_ready), 32'd1);
        run_to(2);
        show("f2_d0", 4'b1110, 6'd4, 1'b1);
        run_to(10);
        chk("f2_d1", 32'(dig_code), 32'd3);

        // ---- Hold valid high across a pending frame ----
        upd_codes = {6'd6, 6'd7, 6'd8, 6'd9};
        upd_dp    = 4'b1111;
        upd_valid = 1'b1;
        tick();
        chk("hold_a_ready", 32'(upd_ready), 32'd0);
        upd_codes = {6'd10, 6'd11, 6'd12, 6'd13};
        upd_dp    = 4'b0000;
        run_to(31);
        chk("hold_blocked", 32'(upd_ready), 32'd0);
        tick();
        chk("hold_ready_back", 32'(upd_ready), 32'd1);
        tick();
        upd_valid = 1'b0;
        chk("hold_b_taken", 32'(upd_ready), 32'd0);
        run_to(2);
        show("fa_d0", 4'b1110, 6'd9, 1'b0);
        run_to(31);
        tick();
        chk("fb_ready", 32'(upd_ready), 32'd1);
        run_to(2);
        show("fb_d0", 4'b1110, 6'd13, 1'b1);

        // ---- en = 0 for 5 cycles in SHOW of idx 2 ----
        run_to(19);
        show("pre_en", 4'b1011, 6'd11, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en0_an", 32'(an), 32'hF);
            chk("en0_dpn", 32'(dp_n), 32'd1);
        end
        en = 1'b1;
        tick();
        show("en_resume", 4'b1011, 6'd11, 1'b1);
        run_to(23);
        chk("en_last", 32'(an), 32'hB);
        tick();
        chk("en_next_blank", 32'(an), 32'hF);

        // ---- Reset mid-SHOW of idx 3 with a frame pending ----
        run_to(26);
        upd_codes = {6'd1, 6'd1, 6'd1, 6'd1};
        upd_dp    = 4'b1111;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("c_pending", 32'(upd_ready), 32'd0);
        tick();
        show("pre_rst", 4'b0111, 6'd10, 1'b1);
        rst_n = 1'b0;
        #1;
        show("async_rst", 4'b1111, 6'h3F, 1'b1);
        chk("async_ready", 32'(upd_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        run_to(2);
        show("rst_d0", 4'b1110, 6'h3F, 1'b1);
        chk("rst_fs2", 32'(frame_start), 32'd1);
        run_to(31);
        tick();
        run_to(2);
        show("rst_no_prom", 4'b1110, 6'h3F, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
